// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the sw_debounce_pr partition payload.
package sw_debounce_pkg;

    localparam int SW_WIDTH           = 8;
    localparam int SW_DEBOUNCE_CYCLES = 16;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch lane: 2-flop synchronizer, stability counter, stable level,
// change pulse and optional press-toggle LED.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int TOGGLE          = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic led_o,
    output logic changed_o
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          changed_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          update;

    // The counter stops at CNT_MAX: the sample that would go past it
    // commits the new level instead, so it can never wrap.
    always_comb begin
        update   = (sync2_q != stable_q) && (cnt_q == CNT_MAX);
        stable_d = update ? sync2_q : stable_q;
        if (sync2_q == stable_q || update)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            changed_q <= update;
        end
    end

    assign changed_o = changed_q;

    if (TOGGLE != 0) begin : g_toggle
        logic led_q, led_d;

        // Only a committed rise flips the LED; committed falls are ignored.
        assign led_d = led_q ^ (update & sync2_q);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) led_q <= 1'b0;
            else         led_q <= led_d;
        end

        assign led_o = led_q;
    end else begin : g_level
        assign led_o = stable_q;
    end

endmodule

// File: rtl/sw_debounce_pr.sv
// PR-region payload: debounces raw switch bits into LED bits, one
// independent debounce_bit lane per switch.
module sw_debounce_pr
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int TOGGLE          = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] sw_changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .TOGGLE          (TOGGLE)
        ) u_bit (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .sw_i      (sw[i]),
            .led_o     (led[i]),
            .changed_o (sw_changed[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce_pr.sv
// Bench for sw_debounce_pr: level and toggle instances against a
// sample-window reference model, plus directed timing checks.
module tb_sw_debounce_pr;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw    = '0;
    logic [W-1:0] led_l, chg_l, led_t, chg_t;

    always #5 clk = ~clk;

    sw_debounce_pr #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .TOGGLE(0)) u_lvl (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led(led_l), .sw_changed(chg_l));

    sw_debounce_pr #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .TOGGLE(1)) u_tgl (
        .clk(clk), .rst_n(rst_n), .sw(sw), .led(led_t), .sw_changed(chg_t));

    int tests = 0;
    int fails = 0;
    int p7    = 0;

    // Reference: a lane commits once its last D synchronized samples taken
    // since the previous commit all disagree with the current level.
    logic [W-1:0] m_s1, m_s2, m_stable, m_tgl, m_chg;
    logic [31:0]  win  [W];
    int           nval [W];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_tgl = '0; m_chg = '0;
        for (int i = 0; i < W; i++) begin
            win[i]  = '0;
            nval[i] = 0;
        end
    endtask

    task automatic tick();
        logic [31:0] mask;
        logic        s, upd;
        mask = (32'h1 << D) - 32'h1;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < W; i++) begin
                s       = m_s2[i];
                win[i]  = {win[i][30:0], s};
                if (nval[i] < 32) nval[i]++;
                upd = (nval[i] >= D) && ((win[i] & mask) == (m_stable[i] ? 32'h0 : mask));
                if (upd) begin
                    m_stable[i] = s;
                    nval[i]     = 0;
                    if (s) m_tgl[i] = ~m_tgl[i];
                end
                m_chg[i] = upd;
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
        @(posedge clk);
        #1;
        chk("model_led_lvl", led_l, m_stable);
        chk("model_chg_lvl", chg_l, m_chg);
        chk("model_led_tgl", led_t, m_tgl);
        chk("model_chg_tgl", chg_t, m_chg);
        if (chg_t[7]) p7++;
    endtask

    initial begin
        int idx;
        model_reset();

        // Reset with switches already set, then release.
        rst_n = 1'b0;
        sw    = 8'hA5;
        repeat (3) tick();
        chk("rst_led", led_l, 8'h00);
        chk("rst_chg", chg_l, 8'h00);
        rst_n = 1'b1;
        repeat (17) tick();
        chk("rel_led_pre", led_l, 8'h00);
        tick();
        chk("rel_led", led_l, 8'hA5);
        chk("rel_chg", chg_l, 8'hA5);
        tick();
        chk("rel_chg_once", chg_l, 8'h00);

        // Clean single-lane step.
        sw = 8'h00;
        repeat (20) tick();
        sw[3] = 1'b1;
        repeat (17) tick();
        chk("step_led_pre", led_l, 8'h00);
        tick();
        chk("step_led", led_l, 8'h08);
        chk("step_chg", chg_l, 8'h08);

        // Bounce on lane 0, then settle high.
        for (int s = 0; s < 12; s++) begin
            sw[0] = (s % 2 == 0);
            repeat (5) tick();
        end
        chk("bnc_led_hold", led_l, 8'h08);
        sw[0] = 1'b1;
        repeat (17) tick();
        chk("bnc_led_pre", led_l, 8'h08);
        tick();
        chk("bnc_led", led_l, 8'h09);
        chk("bnc_chg", chg_l, 8'h01);

        // Reset asserted part-way through qualifying lane 5.
        sw = 8'h00;
        repeat (20) tick();
        sw[5] = 1'b1;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_led", led_l, 8'h00);
        chk("mid_chg", chg_l, 8'h00);
        chk("mid_led_tgl", led_t, 8'h00);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (17) tick();
        chk("mid_requal_pre", led_l, 8'h00);
        tick();
        chk("mid_requal_led", led_l, 8'h20);
        chk("mid_requal_chg", chg_l, 8'h20);

        // Toggle mode: three press/release cycles on lane 7.
        p7 = 0;
        for (int k = 0; k < 3; k++) begin
            sw[7] = 1'b1;
            repeat (20) tick();
            chk("tgl_press", led_t & 8'h80, (k % 2 == 0) ? 8'h80 : 8'h00);
            sw[7] = 1'b0;
            repeat (20) tick();
            chk("tgl_release", led_t & 8'h80, (k % 2 == 0) ? 8'h80 : 8'h00);
        end
        chk("tgl_pulses", W'(p7), 8'd6);

        // All lanes step together.
        sw = 8'h00;
        repeat (20) tick();
        sw = 8'hFF;
        repeat (17) tick();
        chk("par_led_pre", led_l, 8'h00);
        tick();
        chk("par_led", led_l, 8'hFF);
        chk("par_chg", chg_l, 8'hFF);

        // Random flips, mixing glitches with settled changes.
        repeat (400) begin
            if ($urandom_range(7) == 0) begin
                idx = int'($urandom_range(W - 1));
                sw[idx] = ~sw[idx];
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
